// File: rtl/tcm_enc_pkg.sv
// Shared constants and types for the 4D-8PSK TCM encoder front end.
package tcm_enc_pkg;

  typedef enum logic [1:0] {
    CODE_8  = 2'd0,
    CODE_9  = 2'd1,
    CODE_10 = 2'd2,
    CODE_11 = 2'd3
  } code_t;

  localparam int cINFO_BITS [4] = '{8, 9, 10, 11};

  // Parity-check polynomials of the 64-state systematic feedback code (octal).
  localparam logic [6:0] cH0 = 7'o103;
  localparam logic [6:0] cH1 = 7'o006;
  localparam logic [6:0] cH2 = 7'o024;
  localparam logic [6:0] cH3 = 7'o050;

  typedef logic [11:0] sym4d_t;

  function automatic logic [3:0] info_bits(input code_t c);
    return 4'(cINFO_BITS[int'(c)]);
  endfunction

endpackage

// File: rtl/tcm_enc_trellis.sv
// 64-state systematic feedback trellis: parity x0 and next state, with state register.
module tcm_enc_trellis
  import tcm_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr,
  input  logic [3:1] x,
  output logic       x0
);

  logic [5:0] state;
  logic [5:0] s_cur;
  logic [5:0] fb;
  logic [5:0] s_next;

  always_comb begin
    s_cur  = clr ? 6'd0 : state;
    x0     = s_cur[0];
    // fb[i] is the feedback term entering register stage i (h bit i+1).
    fb     = ({6{x0}}   & cH0[6:1]) ^ ({6{x[1]}} & cH1[6:1]) ^
             ({6{x[2]}} & cH2[6:1]) ^ ({6{x[3]}} & cH3[6:1]);
    s_next = {fb[5], s_cur[5:1] ^ fb[4:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= '0;
    else if (ena) state <= s_next;
  end

endmodule

// File: rtl/tcm_enc_coder.sv
// Byte-to-4D-symbol packer plus trellis parity for the 4D-8PSK TCM transmitter.
// Optional: TCM_ENC_CODER_SOP_CLR_EN clears the trellis state on each frame's first word.
module tcm_enc_coder
  import tcm_enc_pkg::*;
(
  input  logic        iclk,
  input  logic        iresetn,
  input  logic        iclkena,
  input  logic [1:0]  icode,
  input  logic        i1sps,
  input  logic        isop,
  input  logic        ieop,
  input  logic        ival,
  input  logic [7:0]  idat,
  output logic        ordy,
  output logic        o1sps,
  output logic        osop,
  output logic        oeop,
  output logic        oval,
  output logic [11:0] odat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [23:0] acc, acc_nxt;
  logic [4:0]  bcnt, bcnt_nxt, bmid;
  logic [1:0]  scnt;
  code_t       fcode;
  logic        sop_pend, sop_pend_nxt;
  logic        tail, accept, push, slot, pop_full, pop_tail, pop, last;
  logic [3:0]  k;
  logic [10:0] info_sh;
  logic        x0, trellis_clr;
  sym4d_t      word;

  // Valid handshake: a byte moves when ival & ordy & iclkena in the same cycle.
  assign tail     = (state == ST_TAIL);
  assign accept   = ival & ordy & iclkena;
  assign push     = accept & ((state != ST_IDLE) | isop);
  assign slot     = iclkena & i1sps & (scnt == 2'd0);
  assign k        = info_bits(fcode);
  assign pop_full = slot & (bcnt >= {1'b0, k});
  assign pop_tail = slot & tail & (bcnt != 5'd0) & ~pop_full;
  assign pop      = pop_full | pop_tail;
  assign bmid     = pop_full ? (bcnt - {1'b0, k}) : (pop_tail ? 5'd0 : bcnt);
  assign last     = pop & tail & (bmid == 5'd0);

  // Bits beyond bcnt are always zero, so a short tail pop pads itself.
  assign info_sh  = acc[23:13] >> (4'd11 - k);
  assign word     = {info_sh, x0};

`ifdef TCM_ENC_CODER_SOP_CLR_EN
  assign trellis_clr = sop_pend;
`else
  assign trellis_clr = 1'b0;
`endif

  tcm_enc_trellis u_trellis (
    .clk   (iclk),
    .rst_n (iresetn),
    .ena   (pop),
    .clr   (trellis_clr),
    .x     (info_sh[2:0]),
    .x0    (x0)
  );

  always_comb begin
    acc_nxt = acc;
    if (pop_full)      acc_nxt = acc << k;
    else if (pop_tail) acc_nxt = '0;
    if (push)          acc_nxt = acc_nxt | ({idat, 16'h0000} >> bmid);
    bcnt_nxt = bmid + (push ? 5'd8 : 5'd0);

    state_nxt    = state;
    sop_pend_nxt = sop_pend & ~pop;
    if (push & isop) begin
      state_nxt    = ieop ? ST_TAIL : ST_RUN;
      sop_pend_nxt = 1'b1;
    end else if (push & ieop) begin
      state_nxt = ST_TAIL;
    end
    if (last) state_nxt = ST_IDLE;
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state    <= ST_IDLE;
      acc      <= '0;
      bcnt     <= '0;
      scnt     <= '0;
      fcode    <= CODE_8;
      sop_pend <= 1'b0;
      ordy     <= 1'b0;
      o1sps    <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      oval     <= 1'b0;
      odat     <= '0;
    end else if (iclkena) begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      bcnt     <= bcnt_nxt;
      sop_pend <= sop_pend_nxt;
      if (i1sps)       scnt  <= scnt + 2'd1;
      if (push & isop) fcode <= code_t'(icode);
      ordy  <= (bcnt_nxt <= 5'd16) & (state_nxt != ST_TAIL);
      o1sps <= i1sps;
      oval  <= pop;
      osop  <= pop & sop_pend;
      oeop  <= last;
      if (pop) odat <= word;
    end
  end

endmodule

// File: doc/tcm_enc_coder.md
# tcm_enc_coder

Byte-to-4D-symbol front end of the 4D-8PSK TCM transmitter, directly upstream of the 8PSK encoder/mapper stage. It accepts a framed byte stream and packs 8/9/10/11 info bits per 4D symbol according to the frame's code rate. It runs the 64-state systematic feedback convolutional encoder that produces parity bit x[0], and emits one 12-bit 4D symbol word every fourth symbol strobe, aligned the way the mapper requires (`oval` only on strobe cycles).

## Interface
Parameters: none (all constants live in the shared package).
- `iclk` in 1: clock
- `iresetn` in 1: asynchronous active-low reset
- `iclkena` in 1: clock enable; all state holds when low
- `icode` in 2: 0/1/2/3 = 2/2.25/2.5/2.75 bit/symbol, giving k = 8/9/10/11 info bits per 4D symbol
- `i1sps` in 1: 8PSK symbol strobe
- `isop`, `ieop` in 1: frame start/end, qualified by `ival`
- `ival` in 1: input byte valid
- `idat` in 8: input byte, MSB transmitted first
- `ordy` out 1: byte accepted when `ival & ordy & iclkena`
- `o1sps` out 1: `i1sps` delayed 1 cycle
- `osop`, `oeop`, `oval` out 1: 4D symbol framing
- `odat` out 12: 4D word; x[k:1] are info bits, x[0] is parity, unused MSBs are 0

## Operation
- Bit accumulator: 24 bits, count `bcnt` 0..24, MSB-first FIFO. `ordy = (bcnt <= 16) & !tail`. An accepted byte is appended at the tail.
- Frame code: `icode` is latched into `fcode` when the `isop` byte is accepted, and held for the whole frame.
- Slot counter `scnt` counts `i1sps` modulo 4. A 4D slot occurs on an `i1sps` cycle with `scnt == 0`.
- At a slot, one of three things happens:
  - `bcnt >= k`: pop k bits. The first popped bit goes to x[k], the last to x[1].
  - `tail` and `bcnt > 0`: pop all remaining bits into x[k] downward and zero-pad the rest. This word carries `oeop`.
  - Otherwise: no symbol. `oval` stays 0 and `bcnt` is unchanged.
- Framing state machine, states IDLE → RUN → TAIL → IDLE:
  - IDLE → RUN: on accepting an `isop` byte.
  - RUN → TAIL: on accepting an `ieop` byte (`tail = 1`, `ordy` forced 0).
  - TAIL → IDLE: on the slot that pops the last bits.
  - `isop & ieop` on the same byte goes straight to TAIL.
  - Bytes offered in IDLE without `isop` are accepted and dropped.
- `osop` is set on the first emitted word after RUN is entered.
- Trellis encoder: state s[5:0], inputs x1..x3 taken from `odat` bits [3:1]. Parity-check polynomials, octal: h0=103, h1=006, h2=024, h3=050.
  - x0 = s[0].
  - For j = 1..5: s[j-1]' = s[j] ^ h0[j]x0 ^ h1[j]x1 ^ h2[j]x2 ^ h3[j]x3.
  - s[5]' = h0[6]x0 ^ h1[6]x1 ^ h2[6]x2 ^ h3[6]x3.
  - The state advances only on emitted words.
- A simultaneous pop and push in one cycle gives `bcnt' = bcnt - pop + 8`. This can never exceed 24.

## Timing
- Reset values: `ordy=0`, `o1sps=0`, `osop=0`, `oeop=0`, `oval=0`, `odat=0`, `s=0`, `bcnt=0`, `scnt=0`, state IDLE. After release, `ordy` rises on the first enabled cycle.
- Output latency: all outputs are registered. `oval` asserts on the cycle after the slot's `i1sps`, coincident with `o1sps`. `odat` holds until the next emitted word.
- `ordy` is a registered function of the post-update `bcnt` and `tail`.
- Reset mid-frame: the frame is discarded, the trellis state is cleared, and no `oeop` is produced.
- If input underruns mid-frame, the slot is skipped. The mapper sees a gap; no filler symbol is produced.

## Configuration
- `TCM_ENC_CODER_SOP_CLR_EN`
  - Defined: s is cleared to 0 when the `osop` word is emitted, so x0 of that word is 0.
  - Undefined: the trellis state runs continuously across frames and is cleared only by reset.

## Structure
- The shared package `tcm_enc_pkg` holds:
  - the `code_t` enum;
  - `cINFO_BITS[4] = '{8,9,10,11}`;
  - the h0..h3 octal constants;
  - the 12-bit `sym4d_t` type.
- One sub-module, `tcm_enc_trellis`: a combinational next-state/parity function plus the state register with enable. It is reused by the decoder-side reference model.

## Test plan
- `icode=0`, bytes 0xFF,0x00 with `isop`/`ieop`, continuous strobes → 2 words:
  - first word: x[8:1]=0xFF, x0=0, `osop=1`;
  - second word: x[8:1]=0x00, `oeop=1`;
  - `oval` exactly every 4th `o1sps`.
- `icode=3`, 11-byte frame (88 bits) → exactly 8 words and no padding. `ordy` never exceeds the bcnt ≤ 16 rule; check bcnt with an assertion.
- `icode=1`, single byte 0xA5 with `isop & ieop` → one word with x[9:2]=0xA5, x[1]=0, `osop=oeop=1`.
- Trellis check: feed x3..x1 = 001 for 7 words from s=0 → the x0 sequence matches the golden model built from h0..h3.
- Input starvation: pause `ival` for 12 strobes mid-frame → 3 slots with `oval=0`; the data sequence resumes unbroken and the trellis state does not advance during the gap.
- Assert `iresetn=0` for 1 cycle mid-frame → all outputs 0 and `ordy=0` during reset; a new `isop` frame then starts from s=0 with the correct `osop`.
